// File: rtl/clock_pkg.sv
// Shared encodings for the clock mode controller: operating modes and time-field indices.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_RUN       = 2'd1,
    MODE_SET       = 2'd2,
    MODE_ALARM_SET = 2'd3
  } mode_e;

  localparam int FIELD_SEC  = 0;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_HOUR = 2;
  localparam int NUM_FIELDS = 3;

endpackage

// File: rtl/clock_ctrl_btn_repeat.sv
// One adjustment button: 2-flop synchronizer, rising-edge strobe, disarm-until-release
// and hold-to-repeat (first repeat after REPEAT_DELAY, then every REPEAT_RATE cycles).
module btn_repeat #(
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic clk_src,
  input  logic reset,
  input  logic btn,
  input  logic allow,
  output logic strobe,
  output logic level
);

  localparam logic [CNT_WIDTH-1:0] DELAY  = CNT_WIDTH'(REPEAT_DELAY);
  localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(REPEAT_DELAY - REPEAT_RATE + 1);

  logic                 meta;
  logic                 sync;
  logic                 sync_d;
  logic                 armed;
  logic                 strobe_q;
  logic [CNT_WIDTH-1:0] hold_cnt;

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      sync_d   <= 1'b0;
      armed    <= 1'b1;
      strobe_q <= 1'b0;
      hold_cnt <= '0;
    end else begin
      meta   <= btn;
      sync   <= meta;
      sync_d <= sync;
      if (!sync) begin
        armed    <= 1'b1;
        strobe_q <= 1'b0;
        hold_cnt <= '0;
      end else if (!allow || !armed) begin
        // Held through a mode change or a conflict: stay silent until released.
        armed    <= 1'b0;
        strobe_q <= 1'b0;
        hold_cnt <= '0;
      end else if (!sync_d) begin
        strobe_q <= 1'b1;
        hold_cnt <= CNT_WIDTH'(1);
      end else if (hold_cnt == DELAY) begin
        // Reloading makes the counter revisit DELAY every REPEAT_RATE cycles.
        strobe_q <= 1'b1;
        hold_cnt <= RELOAD;
      end else begin
        strobe_q <= 1'b0;
        hold_cnt <= hold_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign strobe = strobe_q & allow;
  assign level  = sync;

endmodule

// File: rtl/clock_ctrl.sv
// Mode sequencer (OFF/RUN/SET/ALARM_SET), 1 Hz tick prescaler and per-field inc/dec strobes.
// Strobes are single-cycle pulses with no back-pressure: the datapath must act on every pulse.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV     = 5,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic       clk_src,
  input  logic       reset,
  input  logic       power,
  input  logic       enable,
  input  logic       timing_clock_switch,
  input  logic [2:0] add_time,
  input  logic [2:0] sub_time,
  output logic       tick,
  output logic [2:0] inc,
  output logic [2:0] dec,
  output logic       target,
  output logic       clear,
  output logic [1:0] mode
);

  localparam logic [CNT_WIDTH-1:0] TICK_LAST = CNT_WIDTH'(TICK_DIV - 1);

  logic [2:0]           ctrl_meta;
  logic [2:0]           ctrl_sync;
  mode_e                state;
  mode_e                prev_state;
  mode_e                next_state;
  logic [CNT_WIDTH-1:0] presc;
  logic                 setting;
  logic [2:0]           field_allow;
  logic [2:0]           add_stb;
  logic [2:0]           sub_stb;
  logic [2:0]           add_lvl;
  logic [2:0]           sub_lvl;

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      ctrl_meta  <= '0;
      ctrl_sync  <= '0;
      state      <= MODE_OFF;
      prev_state <= MODE_OFF;
      presc      <= '0;
    end else begin
      ctrl_meta  <= {power, enable, timing_clock_switch};
      ctrl_sync  <= ctrl_meta;
      state      <= next_state;
      prev_state <= state;
      if (state == MODE_OFF) begin
        presc <= '0;
      end else if (state == MODE_RUN) begin
        presc <= (presc == TICK_LAST) ? '0 : presc + CNT_WIDTH'(1);
      end
    end
  end

  // ctrl_sync = {power, enable, timing_clock_switch}
  always_comb begin
    next_state = MODE_SET;
    if (!ctrl_sync[2]) begin
      next_state = MODE_OFF;
    end else if (ctrl_sync[0]) begin
      next_state = MODE_ALARM_SET;
    end else if (ctrl_sync[1]) begin
      next_state = MODE_RUN;
    end
  end

  always_comb begin
    clear  = (state == MODE_OFF);
    target = (state == MODE_ALARM_SET);
    tick   = (state == MODE_RUN) && (presc == TICK_LAST);
    mode   = state;
  end

  // The first cycle in a new mode drops allow, which disarms any button still held.
  assign setting     = ((state == MODE_SET) || (state == MODE_ALARM_SET)) && (state == prev_state);
  assign field_allow = {3{setting}} & ~(add_lvl & sub_lvl);

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
    btn_repeat #(
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_add (
      .clk_src(clk_src),
      .reset  (reset),
      .btn    (add_time[i]),
      .allow  (field_allow[i]),
      .strobe (add_stb[i]),
      .level  (add_lvl[i])
    );

    btn_repeat #(
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_sub (
      .clk_src(clk_src),
      .reset  (reset),
      .btn    (sub_time[i]),
      .allow  (field_allow[i]),
      .strobe (sub_stb[i]),
      .level  (sub_lvl[i])
    );
  end

  assign inc = add_stb & ~sub_stb;
  assign dec = sub_stb & ~add_stb;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed stimulus, expected tick/inc/dec events queued by cycle number.
module tb_clock_ctrl;

  localparam int EW = 39;

  logic       clk_src = 1'b0;
  logic       reset;
  logic       power;
  logic       enable;
  logic       timing_clock_switch;
  logic [2:0] add_time;
  logic [2:0] sub_time;
  logic       tick;
  logic [2:0] inc;
  logic [2:0] dec;
  logic       target;
  logic       clear;
  logic [1:0] mode;

  int unsigned    cyc = 0;
  int             checks = 0;
  int             errors = 0;
  logic [EW-1:0]  exp_q[$];

  clock_ctrl dut (
    .clk_src            (clk_src),
    .reset              (reset),
    .power              (power),
    .enable             (enable),
    .timing_clock_switch(timing_clock_switch),
    .add_time           (add_time),
    .sub_time           (sub_time),
    .tick               (tick),
    .inc                (inc),
    .dec                (dec),
    .target             (target),
    .clear              (clear),
    .mode               (mode)
  );

  // Clock / reset block
  always #5 clk_src = ~clk_src;
  always @(posedge clk_src) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d, simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic go(input int unsigned c);
    while (cyc < c) @(negedge clk_src);
  endtask

  task automatic expect_ev(input int unsigned c, input logic t, input logic [2:0] i,
                           input logic [2:0] d);
    exp_q.push_back({c, t, i, d});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Scoreboard monitor: every cycle showing tick/inc/dec activity consumes one expected event
  always @(negedge clk_src) begin
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    if (!reset && (tick || (inc != 3'b000) || (dec != 3'b000))) begin
      got = {cyc, tick, inc, dec};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cycle %0d tick=%b inc=%b dec=%b", cyc, tick, inc, dec);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL event got cycle %0d t/i/d=%b/%b/%b expected cycle %0d t/i/d=%b/%b/%b",
                   got[38:7], got[6], got[5:3], got[2:0],
                   want[38:7], want[6], want[5:3], want[2:0]);
        end
      end
    end
  end

  initial begin
    int unsigned n;
    reset = 1'b1;
    power = 1'b0;
    enable = 1'b0;
    timing_clock_switch = 1'b0;
    add_time = 3'b000;
    sub_time = 3'b000;
    repeat (3) @(negedge clk_src);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_clear", 32'(clear), 32'd1);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_inc", 32'(inc), 32'd0);
    chk("rst_dec", 32'(dec), 32'd0);
    chk("rst_target", 32'(target), 32'd0);
    reset = 1'b0;

    // Power off: buttons have no effect
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_src);
      add_time = k[2:0];
      sub_time = ~k[2:0];
    end
    @(negedge clk_src);
    add_time = 3'b000;
    sub_time = 3'b000;
    repeat (6) @(negedge clk_src);
    chk("off_mode", 32'(mode), 32'd0);
    chk("off_clear", 32'(clear), 32'd1);

    // RUN: tick every 5 cycles, buttons ignored
    n = cyc;
    power = 1'b1;
    enable = 1'b1;
    expect_ev(n + 7, 1'b1, 3'b000, 3'b000);
    expect_ev(n + 12, 1'b1, 3'b000, 3'b000);
    expect_ev(n + 17, 1'b1, 3'b000, 3'b000);
    expect_ev(n + 22, 1'b1, 3'b000, 3'b000);
    go(n + 10);
    add_time = 3'b111;
    go(n + 11);
    add_time = 3'b000;
    go(n + 20);
    chk("run_mode", 32'(mode), 32'd1);
    chk("run_clear", 32'(clear), 32'd0);
    chk("run_target", 32'(target), 32'd0);
    go(n + 24);
    enable = 1'b0;
    go(n + 30);
    chk("set_mode", 32'(mode), 32'd2);
    chk("set_target", 32'(target), 32'd0);
    chk("set_clear", 32'(clear), 32'd0);

    // SET: hold add[0] for 12 cycles -> strobes at +3, +7, +9, +11, +13
    n = cyc;
    add_time = 3'b001;
    expect_ev(n + 3, 1'b0, 3'b001, 3'b000);
    expect_ev(n + 7, 1'b0, 3'b001, 3'b000);
    expect_ev(n + 9, 1'b0, 3'b001, 3'b000);
    expect_ev(n + 11, 1'b0, 3'b001, 3'b000);
    expect_ev(n + 13, 1'b0, 3'b001, 3'b000);
    go(n + 12);
    add_time = 3'b000;
    go(n + 20);

    // Conflict on field 1, independent field 2 still strobes
    n = cyc;
    add_time = 3'b110;
    sub_time = 3'b010;
    expect_ev(n + 3, 1'b0, 3'b100, 3'b000);
    go(n + 1);
    add_time = 3'b000;
    sub_time = 3'b000;
    go(n + 8);
    n = cyc;
    sub_time = 3'b010;
    expect_ev(n + 3, 1'b0, 3'b000, 3'b010);
    go(n + 1);
    sub_time = 3'b000;
    go(n + 8);

    // ALARM_SET: tap gives one strobe, target=1
    n = cyc;
    timing_clock_switch = 1'b1;
    go(n + 6);
    chk("alarm_mode", 32'(mode), 32'd3);
    chk("alarm_target", 32'(target), 32'd1);
    n = cyc;
    add_time = 3'b001;
    expect_ev(n + 3, 1'b0, 3'b001, 3'b000);
    go(n + 1);
    add_time = 3'b000;
    go(n + 8);

    // Leaving ALARM_SET while held disarms the button until release and re-press
    n = cyc;
    add_time = 3'b001;
    expect_ev(n + 3, 1'b0, 3'b001, 3'b000);
    expect_ev(n + 7, 1'b0, 3'b001, 3'b000);
    expect_ev(n + 27, 1'b0, 3'b001, 3'b000);
    go(n + 6);
    timing_clock_switch = 1'b0;
    go(n + 20);
    chk("back_set_mode", 32'(mode), 32'd2);
    chk("back_set_target", 32'(target), 32'd0);
    add_time = 3'b000;
    go(n + 24);
    add_time = 3'b001;
    go(n + 25);
    add_time = 3'b000;
    go(n + 32);

    // Reset mid auto-repeat
    n = cyc;
    add_time = 3'b001;
    expect_ev(n + 3, 1'b0, 3'b001, 3'b000);
    expect_ev(n + 7, 1'b0, 3'b001, 3'b000);
    go(n + 8);
    reset = 1'b1;
    #1;
    chk("areset_mode", 32'(mode), 32'd0);
    chk("areset_clear", 32'(clear), 32'd1);
    chk("areset_inc", 32'(inc), 32'd0);
    chk("areset_target", 32'(target), 32'd0);
    go(n + 11);
    n = cyc;
    reset = 1'b0;
    add_time = 3'b000;
    enable = 1'b1;
    expect_ev(n + 7, 1'b1, 3'b000, 3'b000);

    // Reset mid-prescaler, then first tick again 4 cycles after entering RUN
    go(n + 9);
    reset = 1'b1;
    #1;
    chk("preset_mode", 32'(mode), 32'd0);
    chk("preset_clear", 32'(clear), 32'd1);
    chk("preset_tick", 32'(tick), 32'd0);
    go(n + 12);
    n = cyc;
    reset = 1'b0;
    expect_ev(n + 7, 1'b1, 3'b000, 3'b000);
    go(n + 10);
    chk("final_mode", 32'(mode), 32'd1);
    chk("pending_events", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
